// File: rtl/apb_regfile_slave.sv
// APB completer serving a NUM_REGS x 32-bit register window with WAIT_CYCLES wait states.
// Optional byte-lane strobes are enabled by defining APB_PSTRB_EN.
module apb_regfile_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
`ifdef APB_PSTRB_EN
    input  logic [3:0]  pstrb,
`endif
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int AW = $clog2(4 * NUM_REGS);
    localparam int IW = AW - 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_WAIT  = 3'b010,
        S_READY = 3'b100
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_wr;
    logic          r_err;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_regs [NUM_REGS];
    logic          r_pready;
    logic          r_pslverr;
    logic [31:0]   r_prdata;

    logic          w_setup;
    logic          w_hit;
    logic [IW-1:0] w_idx;
    logic          w_err;
    logic [3:0]    w_strb;

    assign w_setup = psel & ~penable;
    assign w_hit   = (paddr[31:AW] == BASE_ADDR[31:AW]);
    assign w_idx   = paddr[AW-1:2];
    assign w_err   = ~w_hit | (paddr[1:0] != 2'b00) | (pwrite & (w_idx == '0));

`ifdef APB_PSTRB_EN
    logic [3:0] r_strb;
    assign w_strb = r_strb;
`else
    assign w_strb = 4'hF;
`endif

    function automatic logic [31:0] f_rdata(input logic wr, input logic err,
                                            input logic [IW-1:0] idx,
                                            input logic [31:0] regval);
        if (wr || err)
            return 32'h0;
        else if (idx == '0)
            return ID_VALUE;
        else
            return regval;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= 32'h0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= 32'h0;
`ifdef APB_PSTRB_EN
            r_strb    <= 4'h0;
`endif
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= 32'h0;
                    if (w_setup) begin
                        r_wr    <= pwrite;
                        r_err   <= w_err;
                        r_idx   <= w_idx;
                        r_wdata <= pwdata;
`ifdef APB_PSTRB_EN
                        r_strb  <= pstrb;
`endif
                        // Zero wait states: the response is built from the live bus.
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= S_READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= f_rdata(pwrite, w_err, w_idx, r_regs[w_idx]);
                        end else begin
                            r_cnt   <= 4'(WAIT_CYCLES);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Master abandoned the transfer: drop it silently.
                    if (!psel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (penable) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state   <= S_READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= f_rdata(r_wr, r_err, r_idx, r_regs[r_idx]);
                        end
                    end
                end
                S_READY: begin
                    r_state   <= S_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= 32'h0;
                    if (r_wr && !r_err)
                        r_regs[r_idx] <= f_merge(r_regs[r_idx], r_wdata, w_strb);
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: two instances (0 and 3 wait states) share one APB bus and are
// checked every cycle against a transaction-level model; define APB_PSTRB_EN for strobe builds.
module tb_apb_regfile_slave;

    localparam logic [31:0] BASE = 32'h0000_A000;
    localparam logic [31:0] IDV  = 32'hA5B0_0001;

    logic        clk = 1'b0;
    logic        preset_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    logic [31:0] m [2][16];
    logic        exp_v [2];
    int          exp_c [2];
    logic [31:0] exp_d [2];
    logic        exp_e [2];
    logic [31:0] last_rd [2];
    logic        last_er [2];

    always #5 clk = ~clk;

    apb_regfile_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .pclk(clk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_regfile_slave #(.WAIT_CYCLES(3)) u_dut3 (
        .pclk(clk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        check(name, {2'b00, got}, {2'b00, want});
    endtask

    // Per-cycle response check: {pready, pslverr, prdata} must be zero except on the ready cycle.
    task automatic cycle();
        logic [33:0] want, got;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            want = (exp_v[d] && exp_c[d] == cyc) ? {1'b1, exp_e[d], exp_d[d]} : 34'h0;
            got  = (d == 0) ? {pready0, pslverr0, prdata0} : {pready3, pslverr3, prdata3};
            check(d == 0 ? "resp_wait0" : "resp_wait3", got, want);
            if (got[33]) begin
                last_rd[d] = got[31:0];
                last_er[d] = got[32];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = new_val;
`ifdef APB_PSTRB_EN
        for (int b = 0; b < 4; b++)
            if (!strb[b]) res[8*b +: 8] = old_val[8*b +: 8];
`endif
        return res;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            exp_v[d] = 1'b0;
            for (int i = 0; i < 16; i++) m[d][i] = 32'h0;
        end
    endtask

    // One transfer: drop_at = access cycle where psel falls (0 = none), rst_at = access cycle
    // where reset is asserted (0 = none).
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int drop_at, input int rst_at);
        logic hit, err;
        int   idx, t0;
        hit = (addr >= BASE) && (addr < BASE + 32'd64);
        idx = int'((addr - BASE) >> 2) & 15;
        err = !hit || (addr % 4 != 0) || (wr && idx == 0);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        t0 = cyc;
        for (int d = 0; d < 2; d++) begin
            exp_v[d]   = !(d == 1 && drop_at != 0);
            exp_c[d]   = t0 + 1 + 3 * d;
            exp_e[d]   = err;
            exp_d[d]   = (wr || err) ? 32'h0 : (idx == 0 ? IDV : m[d][idx]);
            last_rd[d] = 32'hDEAD_BEEF;
            last_er[d] = 1'bx;
        end
        cycle();
        for (int k = 1; k <= 4; k++) begin
            if (k == drop_at) begin
                psel = 1'b0; penable = 1'b0;
                cycle();
                break;
            end
            penable = 1'b1;
            if (k == rst_at) begin
                if (k == 4) check("ready_before_rst", {33'h0, pready3}, 34'h1);
                preset_n = 1'b0;
                #1;
                check("rst_async_wait0", {pready0, pslverr0, prdata0}, 34'h0);
                check("rst_async_wait3", {pready3, pslverr3, prdata3}, 34'h0);
                clear_model();
                psel = 1'b0; penable = 1'b0;
                cycle();
                cycle();
                preset_n = 1'b1;
                return;
            end
            cycle();
        end
        if (wr && !err)
            for (int d = 0; d < 2; d++)
                if (d == 0 || drop_at == 0) m[d][idx] = merge(m[d][idx], data, strb);
    endtask

    task automatic rd(input logic [31:0] addr);
        xfer(1'b0, addr, $urandom, 4'hF, 0, 0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        xfer(1'b1, addr, data, strb, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sel, drop;
        preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        clear_model();
        @(posedge clk);
        #1;
        cycle();
        check("reset_outputs", {pready0, pslverr0, prdata0, 1'b0, pready3, pslverr3}, 37'h0);
        preset_n = 1'b1;
        cycle();

        rd(BASE + 32'h4);
        lit("reset_read_w0", last_rd[0], 32'h0);
        lit("reset_read_w3", last_rd[1], 32'h0);

        wr(BASE + 32'h4, 32'h1, 4'hF);
        rd(BASE + 32'h4);
        lit("wr1_read_w0", last_rd[0], 32'h1);
        lit("wr1_read_w3", last_rd[1], 32'h1);
        wr(BASE + 32'h4, 32'h2, 4'hF);
        rd(BASE + 32'h4);
        lit("wr2_read_w0", last_rd[0], 32'h2);
        lit("wr2_read_w3", last_rd[1], 32'h2);
        lit("model_pin_r1", m[0][1], 32'h2);

        rd(BASE + 32'h8);
        lit("wait_read_w3", last_rd[1], 32'h0);

        wr(BASE + 32'h40, 32'h5555_5555, 4'hF);
        check("err_miss", {33'h0, last_er[1]}, 34'h1);
        wr(BASE + 32'h6, 32'h6666_6666, 4'hF);
        check("err_unaligned", {33'h0, last_er[0]}, 34'h1);
        wr(BASE, 32'h7777_7777, 4'hF);
        check("err_ro_write", {33'h0, last_er[1]}, 34'h1);
        rd(BASE);
        lit("id_read_w0", last_rd[0], IDV);
        lit("id_read_w3", last_rd[1], IDV);
        rd(BASE + 32'h4);
        lit("unchanged_r1", last_rd[1], 32'h2);

        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'hC, 32'h1122_3344, 4'b0101);
        rd(BASE + 32'hC);
`ifdef APB_PSTRB_EN
        lit("strobe_merge", last_rd[1], 32'hFF22_FF44);
`else
        lit("strobe_merge", last_rd[1], 32'h1122_3344);
`endif
        wr(BASE + 32'hC, 32'h0BAD_0BAD, 4'b0000);
        check("strb0_no_err", {33'h0, last_er[0]}, 34'h0);

        xfer(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 0, 2);
        rd(BASE + 32'h10);
        lit("rst_discard_w3", last_rd[1], 32'h0);
        wr(BASE + 32'h14, 32'h1234_5678, 4'hF);
        xfer(1'b1, BASE + 32'h18, 32'h8765_4321, 4'hF, 0, 4);
        rd(BASE + 32'h18);
        lit("rst_ready_discard", last_rd[1], 32'h0);
        rd(BASE + 32'h14);
        lit("rst_clears_regs", last_rd[0], 32'h0);

        xfer(1'b1, BASE + 32'h20, 32'hABCD_0001, 4'hF, 2, 0);
        rd(BASE + 32'h20);
        lit("drop_w0_committed", last_rd[0], 32'hABCD_0001);
        lit("drop_w3_no_write", last_rd[1], 32'h0);

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = BASE + 4 * $urandom_range(0, 15);
            else if (sel == 7) a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            else if (sel == 8) a = BASE + 32'd64 + 4 * $urandom_range(0, 63);
            else               a = $urandom;
            drop = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
            xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), drop, 0);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                psel = $urandom_range(0, 1) == 1;
                penable = psel;
                paddr = BASE + 4 * $urandom_range(0, 15);
                pwrite = $urandom_range(0, 1) == 1;
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
